// File: rtl/teclado_pkg.sv
// teclado_pkg -- shared types for the 4x4 keypad reader: FSM state encoding,
// key code type, named key codes and the row/column-to-code map.
package teclado_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_0    = 4'h0;
  localparam key_code_t KEY_1    = 4'h1;
  localparam key_code_t KEY_2    = 4'h2;
  localparam key_code_t KEY_3    = 4'h3;
  localparam key_code_t KEY_4    = 4'h4;
  localparam key_code_t KEY_5    = 4'h5;
  localparam key_code_t KEY_6    = 4'h6;
  localparam key_code_t KEY_7    = 4'h7;
  localparam key_code_t KEY_8    = 4'h8;
  localparam key_code_t KEY_9    = 4'h9;
  localparam key_code_t KEY_A    = 4'hA;
  localparam key_code_t KEY_B    = 4'hB;
  localparam key_code_t KEY_C    = 4'hC;
  localparam key_code_t KEY_D    = 4'hD;
  localparam key_code_t KEY_STAR = 4'hE;
  localparam key_code_t KEY_HASH = 4'hF;

  // Position of the set bit in a one-hot nibble; callers guarantee one-hot.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad layout: rows top to bottom, columns left to right.
  function automatic key_code_t key_map(input logic [3:0] row, input logic [3:0] col);
    key_code_t code;
    case ({onehot_index(row), onehot_index(col)})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador -- N-bit two-flop synchronizer for signals asynchronous to clk.
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a cycle to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make both flops sample their old inputs
    // on the same edge; blocking here would collapse the chain into one flop.
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lector_teclado.sv
// lector_teclado -- 4x4 matrix keypad reader: synchronizes the rows, debounces
// press and release, freezes the column scan while a key is handled, and
// presents one code per press through a valid/ready output register.
// Optional feature: define LECTOR_TECLADO_OVERRUN_EN to enable the sticky
// key_overrun flag (otherwise it is tied low).
module lector_teclado
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  input  logic [3:0] row,
  output logic       scan_hold,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       row_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_lat_q, row_lat_d;
  logic [3:0]       col_lat_q, col_lat_d;
  logic             load;
  key_code_t        key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  sincronizador #(.WIDTH(4)) u_sync_row (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row),
    .q_o   (row_sync)
  );

  // FSM, debounce counter and latched key position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      row_lat_q <= '0;
      col_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_lat_q <= row_lat_d;
      col_lat_q <= col_lat_d;
    end
  end

  // Next-state logic: detect, debounce press, report once, debounce release.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_lat_d = row_lat_q;
    col_lat_d = col_lat_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        // Ghosting (several rows) and a scan between columns are ignored.
        if ($onehot(row_sync) && $onehot(col)) begin
          row_lat_d = row_sync;
          col_lat_d = col;
          cnt_d     = '0;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (row_sync != row_lat_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Any bounce back to a pressed row restarts the release count.
        if (row_sync != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output register next state: a load wins over a same-cycle handshake.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    if (load) begin
      key_code_d  = key_map(row_lat_q, col_lat_q);
      key_valid_d = 1'b1;
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  // Output register holding the last accepted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q  <= KEY_0;
      key_valid_q <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef LECTOR_TECLADO_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky flag: a pending key was overwritten before the consumer took it.
  always_comb begin
    overrun_d = overrun_q;
    if (load && key_valid_q && !key_ready) begin
      overrun_d = 1'b1;
    end
  end

  // Overrun flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign key_overrun = overrun_q;
`else
  assign key_overrun = 1'b0;
`endif

  assign scan_hold = (state_q != IDLE);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule
